muu_resp_serializer: RTL and testbench
======================================

# muu_resp_serializer

Downstream neighbour of the value-get stage in the MUU response path. It accepts the 512-bit response beats (meta + word) produced by the value-get stage and serializes them onto a 64-bit egress stream. Header beats are trimmed to their two meaningful 64-bit words, and value beats are trimmed to the value length carried in the header. Per-beat `last` and the 8-bit user/session tag are carried through to the network packetizer.

## Interface
- `META_WIDTH`, 96, width of the per-response metadata carried with each beat.
- `LEN_BITS`, 10, width of the value-length field (64-bit words) in header word bits [32 +: LEN_BITS].
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `input_data`  in  META_WIDTH+512  {meta, word}; word = bits [511:0].
- `input_user`  in  8  user/session tag of the beat.
- `input_valid`  in  1  beat valid.
- `input_last`  in  1  beat closes an egress packet.
- `input_ready`  out  1  beat accepted when `input_valid && input_ready`.
- `output_data`  out  64  serialized word.
- `output_meta`  out  META_WIDTH  meta of the beat currently being emitted.
- `output_user`  out  8  tag of the beat currently being emitted.
- `output_valid`  out  1  word valid.
- `output_last`  out  1  final word of a beat that had `input_last`.
- `output_ready`  in  1  downstream accepts.
- `stat_responses`  out  32  count of completed responses; wraps at 2^32.

## Operation
**Beat buffer**
- Holds one registered beat `buf` with `buf_valid`, word index `idx` (3 bits) and emit count `cnt` (1..8).
- `output_data = buf.word[64*idx +: 64]`.
- `output_valid = buf_valid`.
- `output_last = buf_last && (idx == cnt-1)`.

**Framing state machine** (tracks response boundaries by length, never by `input_last`)
- `ST_HEAD`
  - An accepted beat is a header.
  - Set `cnt` = 2.
  - Latch `rem` = word[32 +: LEN_BITS].
  - If `rem == 0`: stay in `ST_HEAD` and increment `stat_responses` when the beat's last word is accepted.
  - Else: go to `ST_BODY`.
- `ST_BODY`
  - An accepted beat is a value beat.
  - Set `cnt` = min(8, rem).
  - Set `rem <= rem - cnt`, saturating at 0 (the subtraction is `LEN_BITS` wide).
  - If the new `rem == 0`: return to `ST_HEAD` and increment `stat_responses` when the beat's last word is accepted.
- The state transition and the `rem` update occur at beat acceptance. `stat_responses` lags until emission completes.

**Pass-through and error cases**
- `input_last` is carried unchanged per beat. A mid-response `last` (packet split) gives `output_last` on that beat's final word; framing is unaffected.
- The scan terminator (single beat, word = 0x00000000FEEBDAED, last) is a header with length 0: it emits 2 words, the second with `output_last`=1.
- A header-length field of 0 on a body-expected response cannot occur; no recovery logic beyond length tracking.

## Timing
**Reset**
- `buf_valid`, `output_valid`, `output_last`, `input_ready` = 0.
- `output_data`, `output_meta`, `output_user` = 0.
- `stat_responses` = 0, `rem` = 0, `idx` = 0, state = `ST_HEAD`.
- An assertion mid-beat discards the buffered beat and partial count.
- `input_ready` rises in the first cycle after reset deasserts.

**Input acceptance**
- `input_ready = !buf_valid || (output_valid && output_ready && idx == cnt-1)`. This is combinational from registered state and `output_ready`, with no bubble between beats.
- Latency: beat accepted at cycle t, first word valid at t+1.
- Throughput: a header beat takes 2 cycles; a full value beat takes 8 cycles.

**Handshake rules**
- `idx` advances only on `output_valid && output_ready`.
- `output_data`, `output_meta`, `output_user` and `output_last` stay stable while `output_valid && !output_ready`.
- On a simultaneous final-word handshake and new-beat acceptance: load the new beat, set `idx` = 0, keep `buf_valid` = 1.
- On a final-word handshake without a new beat: `buf_valid` = 0 and `idx` = 0.

## Test plan
- **Header only:** header beat, len=0, last=1, word[127:0]=H.
  - Required: 2 words H[63:0], H[127:64]; `output_last` on the 2nd; `stat_responses`=1; returns to `ST_HEAD`.
- **GET of 11 words:** header len=11, then 2 value beats, last on the 2nd only.
  - Required: 2+8+3 = 13 words; `output_last` only on the 13th; `stat_responses`=1 after the 13th handshake.
- **Back-pressure:** `output_ready` toggles 1,0,0,1 randomly during an 8-word beat.
  - Required: no word lost or duplicated; data and flags stable while stalled.
  - Required: `input_ready` high only in the cycle the 8th word handshakes; the next beat's word 0 appears in the following cycle.
- **Packet split:** header len=24, 3 body beats with last on beats 1 and 3.
  - Required: `output_last` on word 10 and word 26 overall (2 header words + 8 body words, then 16 more); `stat_responses`=1.
- **Scan terminator:** beat word=0xFEEBDAED, last=1 arrives while in `ST_HEAD`.
  - Required: 0x00000000FEEBDAED then 0; last on the 2nd word.
- **Reset mid-beat:** assert `rst` after the 3rd word of a value beat.
  - Required: outputs return to reset values asynchronously.
  - Required: after release, a fresh header len=0 is treated as a header and emits 2 words.

Source files
------------

// File: rtl/muu_resp_serializer_if.sv
// -----------------------------------------------------------------------------
// muu_resp_serializer_if
// Stream bundle for the MUU response serializer.
//   Ingress (512-bit beat + meta): input_data, input_user, input_valid,
//                                  input_last, input_ready
//   Egress  (64-bit words)       : output_data, output_meta, output_user,
//                                  output_valid, output_last, output_ready
// Handshake: a transfer happens on a rising edge where valid && ready. The
// source holds valid and its payload steady until that transfer; ready may
// change freely and may depend combinationally on the opposite side's ready.
// modport slave  : the serializer's view.
// modport master : the view of the surrounding logic (source + sink).
// -----------------------------------------------------------------------------
interface muu_resp_serializer_if #(
  parameter int META_WIDTH = 96
);
  logic [META_WIDTH+511:0] input_data;
  logic [7:0]              input_user;
  logic                    input_valid;
  logic                    input_last;
  logic                    input_ready;

  logic [63:0]             output_data;
  logic [META_WIDTH-1:0]   output_meta;
  logic [7:0]              output_user;
  logic                    output_valid;
  logic                    output_last;
  logic                    output_ready;

  modport slave (
    input  input_data, input_user, input_valid, input_last,
    output input_ready,
    output output_data, output_meta, output_user, output_valid, output_last,
    input  output_ready
  );

  modport master (
    output input_data, input_user, input_valid, input_last,
    input  input_ready,
    input  output_data, output_meta, output_user, output_valid, output_last,
    output output_ready
  );
endinterface

// File: rtl/muu_resp_serializer.sv
// -----------------------------------------------------------------------------
// muu_resp_serializer
// Serializes 512-bit response beats from the value-get stage onto a 64-bit
// egress stream. Header beats emit their two meaningful words; value beats
// emit min(8, remaining length) words. Response boundaries are tracked from
// the header length field only; input_last is carried per beat untouched.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous, active-high reset
//   io             slave stream bundle (see muu_resp_serializer_if)
//   stat_responses out  completed responses, counted when the final word of
//                       the closing beat is handed off; wraps at 2^32
//   o_dbg_state    out  framing state (0 = expecting header, 1 = in body)
// -----------------------------------------------------------------------------
module muu_resp_serializer #(
  parameter int META_WIDTH = 96,
  parameter int LEN_BITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  muu_resp_serializer_if.slave  io,
  output logic [31:0]           stat_responses,
  output logic                  o_dbg_state
);

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Beat buffer
  logic [511:0]            r_buf_word;
  logic [META_WIDTH-1:0]   r_buf_meta;
  logic [7:0]              r_buf_user;
  logic                    r_buf_last;
  logic                    r_buf_end;    // beat closes a response
  logic                    r_buf_valid;
  logic [2:0]              r_idx;
  logic [3:0]              r_cnt;
  logic [LEN_BITS-1:0]     r_rem;
  logic                    r_rdy_en;     // holds input_ready low through reset
  logic [31:0]             r_stat;

  logic                    w_last_word;
  logic                    w_out_fire;
  logic                    w_accept;
  logic                    w_input_ready;
  logic [LEN_BITS-1:0]     w_hdr_len;
  logic [3:0]              w_body_cnt;
  logic [LEN_BITS-1:0]     w_body_rem_next;
  logic [3:0]              w_load_cnt;
  logic                    w_load_end;
  logic [LEN_BITS-1:0]     w_rem_load;

  assign w_hdr_len   = io.input_data[32 +: LEN_BITS];
  assign w_last_word = ({1'b0, r_idx} == (r_cnt - 4'd1));
  assign w_out_fire  = r_buf_valid && io.output_ready;
  assign w_accept    = io.input_valid && w_input_ready;

  // Value-beat word count and the remaining length after this beat.
  always_comb begin
    w_body_cnt = 4'd8;
    if (r_rem == '0) begin
      // Cannot occur for well-formed traffic; one word keeps the beat finite.
      w_body_cnt = 4'd1;
    end else if (r_rem < LEN_BITS'(8)) begin
      w_body_cnt = r_rem[3:0];
    end
  end

  assign w_body_rem_next = (r_rem > LEN_BITS'(w_body_cnt))
                         ? (r_rem - LEN_BITS'(w_body_cnt)) : '0;

  // ---------------------------------------------------------------------------
  // Framing FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HEAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Framing FSM: next state, evaluated at beat acceptance
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_HEAD: if (w_hdr_len != '0)       w_state_next = ST_BODY;
        ST_BODY: if (w_body_rem_next == '0) w_state_next = ST_HEAD;
        default: w_state_next = ST_HEAD;
      endcase
    end
  end

  // Framing FSM: outputs (load values for the beat buffer, ingress ready)
  always_comb begin
    w_load_cnt    = 4'd2;
    w_load_end    = (w_hdr_len == '0);
    w_rem_load    = w_hdr_len;
    if (r_state == ST_BODY) begin
      w_load_cnt  = w_body_cnt;
      w_load_end  = (w_body_rem_next == '0);
      w_rem_load  = w_body_rem_next;
    end
    // Accept a new beat when empty, or in the cycle the final word leaves,
    // so back-to-back beats have no bubble.
    w_input_ready = r_rdy_en && (!r_buf_valid || (w_out_fire && w_last_word));
  end

  // ---------------------------------------------------------------------------
  // Beat buffer, word index, remaining length and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_word  <= '0;
      r_buf_meta  <= '0;
      r_buf_user  <= '0;
      r_buf_last  <= 1'b0;
      r_buf_end   <= 1'b0;
      r_buf_valid <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_rdy_en    <= 1'b0;
      r_stat      <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_buf_word  <= io.input_data[511:0];
        r_buf_meta  <= io.input_data[META_WIDTH+511:512];
        r_buf_user  <= io.input_user;
        r_buf_last  <= io.input_last;
        r_buf_end   <= w_load_end;
        r_buf_valid <= 1'b1;
        r_idx       <= '0;
        r_cnt       <= w_load_cnt;
        r_rem       <= w_rem_load;
      end else if (w_out_fire) begin
        if (w_last_word) begin
          r_buf_valid <= 1'b0;
          r_idx       <= '0;
        end else begin
          r_idx       <= r_idx + 3'd1;
        end
      end
      // The count lags acceptance: it moves when the closing word leaves.
      if (w_out_fire && w_last_word && r_buf_end) begin
        r_stat <= r_stat + 32'd1;
      end
    end
  end

  assign io.input_ready  = w_input_ready;
  assign io.output_data  = r_buf_word[{r_idx, 6'd0} +: 64];
  assign io.output_meta  = r_buf_meta;
  assign io.output_user  = r_buf_user;
  assign io.output_valid = r_buf_valid;
  assign io.output_last  = r_buf_last && w_last_word;
  assign stat_responses  = r_stat;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_muu_resp_serializer.sv
module tb_muu_resp_serializer;
  localparam int META  = 96;
  localparam int EXP_W = 64 + META + 8 + 2;  // {data, meta, user, last, eob}
  localparam int TBL_RESP = 7;

  typedef struct {
    logic [511:0]    word;
    logic [META-1:0] meta;
    logic [7:0]      user;
    logic            last;
    bit              use_model;
    int              exp_words;
  } beat_t;

  typedef struct {
    logic [511:0] word;
    logic         last;
    int           exp_words;
    int           exp_stat;   // -1: no stat check after this entry
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muu_resp_serializer_if #(.META_WIDTH(META)) io ();
  logic [31:0] stat_responses;
  logic        dbg_state;

  muu_resp_serializer #(.META_WIDTH(META), .LEN_BITS(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .io             (io),
    .stat_responses (stat_responses),
    .o_dbg_state    (dbg_state)
  );

  // Ingress may only be ready from the first edge after reset release.
  logic ready_en;
  always @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  beat_t            beat_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  words_seen = 0;
  bit  has_beat = 0;
  bit  stalled_prev = 0;
  logic [63:0]     prev_data;
  logic [META-1:0] prev_meta;
  logic [7:0]      prev_user;
  logic            prev_last;
  int  rdy_pct = 100;
  int  vld_pct = 100;

  // reference model of the framing rules
  bit  m_in_body = 0;
  int  m_left = 0;
  int  m_resp = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[32*k +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [511:0] hdr_word(input int len);
    logic [511:0] w;
    w = rand_word();
    w[32 +: 10] = 10'(len);
    return w;
  endfunction

  function automatic int model_words(input logic [511:0] w);
    int n;
    int len;
    if (!m_in_body) begin
      n = 2;
      len = int'(w[32 +: 10]);
      if (len == 0) m_resp++;
      else begin
        m_in_body = 1;
        m_left = len;
      end
    end else begin
      n = (m_left > 8) ? 8 : m_left;
      m_left -= n;
      if (m_left == 0) begin
        m_in_body = 0;
        m_resp++;
      end
    end
    return n;
  endfunction

  task automatic push_expect(input beat_t b);
    int n;
    n = b.use_model ? model_words(b.word) : b.exp_words;
    for (int j = 0; j < n; j++)
      exp_q.push_back({b.word[64*j +: 64], b.meta, b.user, b.last && (j == n-1), j == n-1});
  endtask

  task automatic enq(input logic [511:0] w, input logic last, input bit use_model, input int exp_words);
    beat_t b;
    b.word = w;
    b.meta = {$urandom(), $urandom(), $urandom()};
    b.user = 8'($urandom());
    b.last = last;
    b.use_model = use_model;
    b.exp_words = exp_words;
    beat_q.push_back(b);
  endtask

  // ---------------- driver / monitor: one clock cycle ----------------
  task automatic step();
    logic [EXP_W-1:0] e;
    logic fire_o, fire_i, eob, exp_ready;
    @(negedge clk);
    fire_o = has_beat && io.output_ready;
    eob = (exp_q.size() > 0) ? exp_q[0][0] : 1'b1;
    exp_ready = ready_en && (!has_beat || (fire_o && eob));
    chk("output_valid", io.output_valid, has_beat);
    chk("input_ready", io.input_ready, exp_ready);
    if (stalled_prev) begin
      chk("stall_data", io.output_data, prev_data);
      chk("stall_meta", io.output_meta, prev_meta);
      chk("stall_user", io.output_user, prev_user);
      chk("stall_last", io.output_last, prev_last);
    end
    if (fire_o) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        chk("exp_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("output_data", io.output_data, e[EXP_W-1 -: 64]);
        chk("output_meta", io.output_meta, e[EXP_W-65 -: META]);
        chk("output_user", io.output_user, e[9:2]);
        chk("output_last", io.output_last, e[1]);
      end
    end
    stalled_prev = has_beat && !io.output_ready;
    prev_data = io.output_data;
    prev_meta = io.output_meta;
    prev_user = io.output_user;
    prev_last = io.output_last;
    fire_i = io.input_valid && exp_ready;
    @(posedge clk);
    #1;
    if (fire_o && eob) has_beat = 0;
    if (fire_i) begin
      push_expect(beat_q.pop_front());
      has_beat = 1;
    end
    io.output_ready = ($urandom_range(99) < rdy_pct);
    if (!(io.input_valid && !fire_i)) begin
      if (beat_q.size() > 0 && $urandom_range(99) < vld_pct) begin
        io.input_valid = 1'b1;
        io.input_data  = {beat_q[0].meta, beat_q[0].word};
        io.input_user  = beat_q[0].user;
        io.input_last  = beat_q[0].last;
      end else begin
        io.input_valid = 1'b0;
        io.input_data  = {$urandom(), $urandom(), $urandom(), rand_word()};
        io.input_user  = 8'($urandom());
        io.input_last  = 1'($urandom());
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((beat_q.size() > 0 || has_beat || io.input_valid) && k < 20000) begin
      step();
      k++;
    end
    if (k >= 20000) chk("drain_timeout", 1, 0);
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_output_valid"}, io.output_valid, 0);
    chk({tag, "_output_last"},  io.output_last, 0);
    chk({tag, "_input_ready"},  io.input_ready, 0);
    chk({tag, "_output_data"},  io.output_data, 0);
    chk({tag, "_output_meta"},  io.output_meta, 0);
    chk({tag, "_output_user"},  io.output_user, 0);
    chk({tag, "_stat"},         stat_responses, 0);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[14];

  initial begin
    logic [511:0] term;
    int base;
    int k;
    int len;
    int nb;
    int rem;

    io.input_valid  = 1'b0;
    io.input_data   = '0;
    io.input_user   = '0;
    io.input_last   = 1'b0;
    io.output_ready = 1'b0;

    term = '0;
    term[63:0] = 64'h0000_0000_FEEB_DAED;
    // header-only, GET of 11, split packet, terminator, short GET, back-pressure
    tbl[0]  = '{hdr_word(0),  1'b1, 2, 1};
    tbl[1]  = '{hdr_word(11), 1'b0, 2, -1};
    tbl[2]  = '{rand_word(),  1'b0, 8, -1};
    tbl[3]  = '{rand_word(),  1'b1, 3, 2};
    tbl[4]  = '{hdr_word(24), 1'b0, 2, -1};
    tbl[5]  = '{rand_word(),  1'b1, 8, -1};
    tbl[6]  = '{rand_word(),  1'b0, 8, -1};
    tbl[7]  = '{rand_word(),  1'b1, 8, 3};
    tbl[8]  = '{term,         1'b1, 2, 4};
    tbl[9]  = '{hdr_word(5),  1'b0, 2, -1};
    tbl[10] = '{rand_word(),  1'b1, 5, 5};
    tbl[11] = '{hdr_word(8),  1'b0, 2, -1};
    tbl[12] = '{rand_word(),  1'b1, 8, -1};
    tbl[13] = '{hdr_word(0),  1'b1, 2, 7};

    // reset state
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // table-driven phase: first pass at full rate, then repeat with stalls
    rdy_pct = 100;
    vld_pct = 100;
    for (int i = 0; i < 14; i++) begin
      enq(tbl[i].word, tbl[i].last, 0, tbl[i].exp_words);
      if (tbl[i].exp_stat >= 0) begin
        drain();
        chk($sformatf("stat_tbl%0d", i), stat_responses, tbl[i].exp_stat);
      end
    end
    rdy_pct = 50;
    for (int i = 0; i < 14; i++) begin
      enq(tbl[i].word, tbl[i].last, 0, tbl[i].exp_words);
      if (tbl[i].exp_stat >= 0) begin
        drain();
        chk($sformatf("stat_bp%0d", i), stat_responses, TBL_RESP + tbl[i].exp_stat);
      end
    end

    // randomized phase against the framing model
    rdy_pct = 60;
    vld_pct = 70;
    m_in_body = 0;
    m_left = 0;
    m_resp = 0;
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(0, 30);
      enq(hdr_word(len), 1'($urandom_range(1)), 1, 0);
      nb = (len + 7) / 8;
      for (int b = 0; b < nb; b++)
        enq(rand_word(), ($urandom_range(99) < 40) || (b == nb-1), 1, 0);
      if (r % 10 == 9) begin
        drain();
        chk($sformatf("stat_rand%0d", r), stat_responses, 2*TBL_RESP + m_resp);
      end
    end

    // reset in the middle of a value beat (after its 3rd word)
    rdy_pct = 100;
    vld_pct = 100;
    base = words_seen;
    enq(hdr_word(8), 1'b0, 0, 2);
    enq(rand_word(), 1'b1, 0, 8);
    k = 0;
    while (words_seen < base + 5 && k < 200) begin
      step();
      k++;
    end
    if (k >= 200) chk("midbeat_timeout", 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midbeat");
    beat_q.delete();
    exp_q.delete();
    has_beat = 0;
    stalled_prev = 0;
    io.input_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    enq(hdr_word(0), 1'b1, 0, 2);
    drain();
    chk("stat_after_reset", stat_responses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
